// File: rtl/sw_array_ctrl.sv
// Job controller for the Smith-Waterman systolic PE array: loads the query
// chain, streams target bases into PE0 with array-wide stall, drains the
// pipeline and returns the last PE's running maximum as the job score.
module sw_array_ctrl #(
  parameter int NUM_PE   = 64,
  parameter int CALC_BIT = 16,
  parameter int LEN_BIT  = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [LEN_BIT-1:0]  q_len,
  input  logic [LEN_BIT-1:0]  t_len,
  input  logic                q_valid,
  output logic                q_ready,
  input  logic [1:0]          q_data,
  input  logic                t_valid,
  output logic                t_ready,
  input  logic [1:0]          t_data,
  output logic [2:0]          arr_t,
  output logic                arr_q_shift,
  output logic [2:0]          arr_q_data,
  output logic                arr_en,
  input  logic [CALC_BIT-1:0] arr_max,
  output logic                busy,
  output logic                done,
  output logic [CALC_BIT-1:0] score,
  output logic                err
);

  localparam logic [LEN_BIT-1:0] NPE        = LEN_BIT'(NUM_PE);
  localparam logic [LEN_BIT-1:0] DRAIN_LAST = LEN_BIT'(NUM_PE + 1);

  // The drain bound NUM_PE+2 has to be representable in the counters.
  generate
    if ((NUM_PE + 2) > ((1 << LEN_BIT) - 1)) begin : g_len_chk
      $error("sw_array_ctrl: NUM_PE+2 does not fit in LEN_BIT");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_Q, S_COMMIT, S_STREAM, S_DRAIN, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [LEN_BIT-1:0]   q_len_q, q_len_d, t_len_q, t_len_d;
  logic [LEN_BIT-1:0]   qc_q, qc_d, tc_q, tc_d, dc_q, dc_d;
  logic                 bad_q, bad_d;
  logic                 q_ready_q, q_ready_d, t_ready_q, t_ready_d;
  logic [2:0]           arr_t_q, arr_t_d, arr_q_data_q, arr_q_data_d;
  logic                 arr_q_shift_q, arr_q_shift_d, arr_en_q, arr_en_d;
  logic                 busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [CALC_BIT-1:0]  score_q, score_d;

  // Next-state and registered-output decode. Every output is computed one
  // cycle ahead so the ports come straight from flops; the ready flags are
  // derived from the next state so a handshake never over-accepts.
  always_comb begin
    state_d       = state_q;
    q_len_d       = q_len_q;
    t_len_d       = t_len_q;
    qc_d          = qc_q;
    tc_d          = tc_q;
    dc_d          = dc_q;
    bad_d         = bad_q;
    q_ready_d     = 1'b0;
    t_ready_d     = 1'b0;
    arr_t_d       = 3'b000;
    arr_en_d      = 1'b1;
    arr_q_shift_d = 1'b0;
    arr_q_data_d  = 3'b000;
    busy_d        = busy_q;
    done_d        = 1'b0;
    score_d       = score_q;
    err_d         = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          q_len_d = q_len;
          t_len_d = t_len;
          qc_d    = '0;
          tc_d    = '0;
          dc_d    = '0;
          busy_d  = 1'b1;
          if (q_len == '0 || q_len > NPE || t_len == '0) begin
            bad_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            bad_d     = 1'b0;
            state_d   = S_LOAD_Q;
            q_ready_d = 1'b1;
          end
        end
      end
      S_LOAD_Q: begin
        if (qc_q < q_len_q) begin
          // real query bases only move on an accepted beat
          if (q_ready_q && q_valid) begin
            arr_q_shift_d = 1'b1;
            arr_q_data_d  = {1'b1, q_data};
            qc_d          = qc_q + 1'b1;
          end
        end else begin
          // pad the rest of the chain with invalid entries, one per cycle
          arr_q_shift_d = 1'b1;
          qc_d          = qc_q + 1'b1;
        end
        if (qc_d == NPE) state_d = S_COMMIT;
        q_ready_d = (qc_d != NPE) && (qc_d < q_len_q);
      end
      S_COMMIT: begin
        arr_t_d   = 3'b001;
        state_d   = S_STREAM;
        t_ready_d = 1'b1;
      end
      S_STREAM: begin
        if (t_ready_q && t_valid) begin
          arr_t_d = {1'b1, t_data};
          tc_d    = tc_q + 1'b1;
        end else begin
          // freeze the whole array instead of injecting a bubble
          arr_en_d = 1'b0;
          arr_t_d  = arr_t_q;
        end
        if (tc_d == t_len_q) state_d = S_DRAIN;
        else                 t_ready_d = 1'b1;
      end
      S_DRAIN: begin
        dc_d = dc_q + 1'b1;
        if (dc_q == DRAIN_LAST) state_d = S_DONE;
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        err_d   = bad_q;
        score_d = bad_q ? '0 : arr_max;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      q_len_q       <= '0;
      t_len_q       <= '0;
      qc_q          <= '0;
      tc_q          <= '0;
      dc_q          <= '0;
      bad_q         <= 1'b0;
      q_ready_q     <= 1'b0;
      t_ready_q     <= 1'b0;
      arr_t_q       <= 3'b000;
      arr_en_q      <= 1'b0;
      arr_q_shift_q <= 1'b0;
      arr_q_data_q  <= 3'b000;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      score_q       <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      q_len_q       <= q_len_d;
      t_len_q       <= t_len_d;
      qc_q          <= qc_d;
      tc_q          <= tc_d;
      dc_q          <= dc_d;
      bad_q         <= bad_d;
      q_ready_q     <= q_ready_d;
      t_ready_q     <= t_ready_d;
      arr_t_q       <= arr_t_d;
      arr_en_q      <= arr_en_d;
      arr_q_shift_q <= arr_q_shift_d;
      arr_q_data_q  <= arr_q_data_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      score_q       <= score_d;
      err_q         <= err_d;
    end
  end

  assign q_ready     = q_ready_q;
  assign t_ready     = t_ready_q;
  assign arr_t       = arr_t_q;
  assign arr_en      = arr_en_q;
  assign arr_q_shift = arr_q_shift_q;
  assign arr_q_data  = arr_q_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign score       = score_q;
  assign err         = err_q;

endmodule

// File: doc/sw_array_ctrl.md
# sw_array_ctrl

Job controller for the Smith-Waterman systolic PE array. It accepts one alignment job per `start` pulse and loads the query bases into the PE query chain. It then streams target bases into PE0 under valid/ready flow control, stalling the whole array whenever the target source runs dry. Finally it drains the pipeline and returns the maximum local-alignment score taken from the last PE's `max_out`.

## Interface
- `NUM_PE`, default 64: number of PEs in the chain; also the maximum query length.
- `CALC_BIT`, default 16: score width; must match the array datapath.
- `LEN_BIT`, default 10: width of the length fields and of the internal counters.

Reset and clocking: reset `rst_n`, asynchronous, active-low; clock `clk`.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle job start; honoured only in IDLE.
- `q_len`  in  LEN_BIT  query length, legal range 1..NUM_PE; sampled on `start`.
- `t_len`  in  LEN_BIT  target length, legal range ≥1; sampled on `start`.
- `q_valid` / `q_ready` / `q_data`  in / out / in  1 / 1 / 2  query base stream.
- `t_valid` / `t_ready` / `t_data`  in / out / in  1 / 1 / 2  target base stream.
- `arr_t`  out  3  t_in to PE0. Bit 2 is valid, bits 1:0 are the base; 3'b001 is the query-commit token.
- `arr_q_shift`  out  1  shifts `arr_q_data` into the query chain. The chain enters at PE NUM_PE-1 and moves toward PE0.
- `arr_q_data`  out  3  query entry. Bit 2 is valid, bits 1:0 are the base.
- `arr_en`  out  1  array-wide register enable; 0 freezes every PE register.
- `arr_max`  in  CALC_BIT  max_out of PE NUM_PE-1.
- `busy`  out  1  high from `start` acceptance until `done`.
- `done`  out  1  one-cycle pulse; `score` and `err` are valid on this cycle.
- `score`  out  CALC_BIT  job result; held until the next `done`.
- `err`  out  1  set when the job had an illegal length; held like `score`.

## Operation
- All outputs are registered. Every output resets to 0, and the FSM resets to IDLE.
- **IDLE**
  - Drives `arr_en=1` and `arr_t=3'b000`, so the array flushes zeros.
  - On `start`, latches `q_len`/`t_len` and clears the counters.
  - If `q_len==0`, `q_len>NUM_PE` or `t_len==0`, goes to DONE with `err=1` and `score=0`. Otherwise goes to LOAD_Q.
- **LOAD_Q**: the shift counter `qc` runs 0..NUM_PE-1.
  - While `qc<q_len`: `q_ready=1`. Each accepted beat shifts `{1,q_data}` and increments `qc`. No shift occurs without a beat.
  - While `qc≥q_len`: `q_ready=0`. One padding entry 3'b000 is shifted per cycle.
  - After NUM_PE shifts, goes to COMMIT.
  - Result: q[0] ends in PE0 and padding fills PEs q_len..NUM_PE-1.
- **COMMIT**: drives `arr_t=3'b001` for exactly one cycle with `arr_en=1`, then goes to STREAM.
- **STREAM**: `t_ready=1`, and the counter `tc` counts accepted beats.
  - On a beat: `arr_t={1,t_data}`, `arr_en=1`, `tc++`.
  - With no beat: `arr_en=0`. `arr_t` holds its last value, so the array is frozen with no bubble injected.
  - When `tc` reaches `t_len`, `t_ready` drops on the following cycle and the FSM goes to DRAIN.
- **DRAIN**: `arr_t=3'b000` and `arr_en=1` for NUM_PE+2 cycles, counted by `dc`. Then goes to DONE.
- **DONE**
  - On a normal job: `score<=arr_max`, `err<=0`.
  - Pulses `done=1` for one cycle, clears `busy`, and returns to IDLE.
- `start` outside IDLE is ignored.
- `q_valid` is ignored outside LOAD_Q, and `t_valid` is ignored outside STREAM.
- Counter widths are LEN_BIT. The bound NUM_PE+2 must fit in LEN_BIT, which is checked at elaboration.

## Timing
- The cycle `start` is sampled is cycle 0, and `busy=1` from cycle 1.
- Minimum job latency, with no source stalls: 1 + NUM_PE + 1 + t_len + (NUM_PE+2) + 1 cycles from `start` to `done`.
- Each cycle of `q_valid=0` while `qc<q_len` adds one cycle.
- Each cycle of `t_valid=0` in STREAM adds one cycle, and `arr_en=0` on exactly those cycles.
- Illegal-length jobs raise `done` at cycle 2 (IDLE→DONE→`done`).
- Back-to-back jobs: `start` is accepted on the cycle after `done`.
- If reset is asserted mid-job:
  - All outputs clear to 0 immediately (asynchronously) and the FSM returns to IDLE.
  - No `done` is produced, and the partial job is discarded.
  - Sources must re-present their data.

## Test plan
Bench parameters: NUM_PE=4, CALC_BIT=16. A behavioural PE array provides `arr_max`.

- q="ACGT" (q_len=4), t="ACGT", no stalls:
  - Exactly 4 shifts, then 3'b001 for one cycle, then 4 target beats.
  - `done` at cycle 17, with `score` equal to the model's 4×match.
- q_len=2 (q="AC"):
  - Shift sequence is 3'b100, 3'b101, 3'b000, 3'b000.
  - `q_ready` is low after 2 beats.
- `t_valid` toggles 1,0,0,1,1,0,1 with t_len=4:
  - `arr_en=0` on exactly the 3 idle cycles, and `arr_t` never shows a bubble.
  - `done` is 3 cycles later than the unstalled case.
- start with q_len=0, and separately q_len=5 and t_len=0:
  - `done` at cycle 2 with `err=1`, `score=0`.
  - No shifts and no `t_ready`.
- Reset asserted in STREAM after 2 beats:
  - All outputs are 0 in the same cycle, and the FSM is in IDLE.
  - A fresh job then completes with the correct score.
- `start` pulsed during DRAIN: it is ignored, with exactly one `done` produced and `busy` unaffected.
